// File: rtl/pixel_ctrl_pkg.sv
// Shared types for the pixel array frame sequencer: state encoding, per-state
// control vector and the cycle-counter width calculation.
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CNT_RST,
        CONVERT,
        RD_RST,
        READ,
        DONE
    } state_t;

    typedef struct packed {
        logic ready;
        logic erase;
        logic expose;
        logic counter_reset;
        logic convert;
        logic write_enable;
        logic read_reset;
        logic read_en;
        logic frame_done;
    } ctrl_out_t;

    // Moore decode: every control pin is a pure function of the state.
    function automatic ctrl_out_t state_outputs(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            IDLE:    o.ready = 1'b1;
            ERASE:   begin o.erase = 1'b1;         o.write_enable = 1'b1; end
            EXPOSE:  begin o.expose = 1'b1;        o.write_enable = 1'b1; end
            CNT_RST: begin o.counter_reset = 1'b1; o.write_enable = 1'b1; end
            CONVERT: begin o.convert = 1'b1;       o.write_enable = 1'b1; end
            RD_RST:  o.read_reset = 1'b1;
            READ:    o.read_en = 1'b1;
            DONE:    o.frame_done = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic int cnt_width(input int exp_w, input int data_w,
                                     input int erase_c, input int rows);
        int w;
        w = exp_w;
        if (data_w + 1 > w)        w = data_w + 1;
        if ($clog2(erase_c) > w)   w = $clog2(erase_c);
        if ($clog2(rows) > w)      w = $clog2(rows);
        return w;
    endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module ctrl_cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for PIXEL_ARRAY: one start runs erase, expose, counter reset,
// ramp conversion and readout, with all control pins registered from the next state.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_ROWS     = 2,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_WIDTH-1:0] expose_cycles,
    output logic                 ready,
    output logic                 erase,
    output logic                 expose,
    output logic                 counter_reset,
    output logic                 convert,
    output logic                 write_enable,
    output logic                 read_reset,
    output logic                 read_en,
    output logic                 frame_done
);

    localparam int CNT_W = cnt_width(EXP_WIDTH, DATA_WIDTH, ERASE_CYCLES, NUM_ROWS);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'((2 ** DATA_WIDTH) - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(NUM_ROWS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [EXP_WIDTH-1:0] r_exp;
    ctrl_out_t            r_out;
    logic                 w_cnt_zero;
    logic                 w_load;
    logic [CNT_W-1:0]     w_load_val;
    logic [CNT_W-1:0]     w_exp_load;

    // A zero exposure request still gets one EXPOSE cycle.
    assign w_exp_load = (r_exp == '0) ? '0 : (CNT_W'(r_exp) - ONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)      w_state_next = ERASE;
            ERASE:   if (w_cnt_zero) w_state_next = EXPOSE;
            EXPOSE:  if (w_cnt_zero) w_state_next = CNT_RST;
            CNT_RST: if (w_cnt_zero) w_state_next = CONVERT;
            CONVERT: if (w_cnt_zero) w_state_next = RD_RST;
            RD_RST:  if (w_cnt_zero) w_state_next = READ;
            READ:    if (w_cnt_zero) w_state_next = DONE;
            DONE:    if (w_cnt_zero) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Counter is loaded with (duration - 1) of the state being entered.
    always_comb begin
        w_load     = (w_state_next != r_state);
        w_load_val = '0;
        case (w_state_next)
            ERASE:   w_load_val = ERASE_LOAD;
            EXPOSE:  w_load_val = w_exp_load;
            CONVERT: w_load_val = CONV_LOAD;
            READ:    w_load_val = READ_LOAD;
            default: w_load_val = '0;
        endcase
    end

    ctrl_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_out   <= state_outputs(IDLE);
        end else begin
            r_state <= w_state_next;
            r_out   <= state_outputs(w_state_next);
            if (r_state == IDLE && start) begin
                r_exp <= expose_cycles;
            end
        end
    end

    assign ready         = r_out.ready;
    assign erase         = r_out.erase;
    assign expose        = r_out.expose;
    assign counter_reset = r_out.counter_reset;
    assign convert       = r_out.convert;
    assign write_enable  = r_out.write_enable;
    assign read_reset    = r_out.read_reset;
    assign read_en       = r_out.read_en;
    assign frame_done    = r_out.frame_done;

endmodule
